// File: rtl/conv3x3_seq_ctrl_if.sv
// conv3x3_seq_ctrl_if: buffer-read, PE-control and output-handshake bundle
// between the 3x3 sequencer (master) and the PE / buffers (slave).
interface conv3x3_seq_ctrl_if #(
   parameter int ADDR_W  = 6,
   parameter int OADDR_W = 6
);
   logic [ADDR_W-1:0]  in_addr;
   logic               in_re;
   logic [3:0]         f_addr;
   logic [1:0]         pe_mode;
   logic               pe_done;
   logic [7:0]         pe_result;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_data;
   logic [OADDR_W-1:0] out_addr;

   modport master (
      output in_addr, in_re, f_addr, pe_mode, out_valid, out_data, out_addr,
      input  pe_done, pe_result, out_ready
   );

   modport slave (
      input  in_addr, in_re, f_addr, pe_mode, out_valid, out_data, out_addr,
      output pe_done, pe_result, out_ready
   );
endinterface

// File: rtl/conv3x3_seq_ctrl.sv
// conv3x3_seq_ctrl: walks a 3x3 stride-1 window over an IMG_W x IMG_H map,
// issues input/filter reads, aligns the PE accumulate enable with returning
// data and hands each result to the output buffer over valid/ready.
// Optional build macro CONV_TIMEOUT_EN adds a WAIT-state watchdog and a
// sticky err flag; without it err is tied to 0.
module conv3x3_seq_ctrl #(
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int ADDR_W  = 6,
   parameter int OADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   conv3x3_seq_ctrl_if.master       bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_DRAIN, S_WAIT, S_OUT, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [3:0]        tap;
   logic [3:0]        ky, kx;
   logic [1:0]        vld_pipe;
   logic [7:0]        out_data_q;
   logic [ADDR_W-1:0] pix_addr;
   logic              col_last, row_last, wd_expire;

   assign col_last = (col >= CW'(IMG_W - 3));
   assign row_last = (row >= RW'(IMG_H - 3));
   assign ky       = tap / 4'd3;
   assign kx       = tap % 4'd3;
   assign pix_addr = (ADDR_W'(row) + ADDR_W'(ky)) * ADDR_W'(IMG_W)
                   + ADDR_W'(col) + ADDR_W'(kx);

`ifdef CONV_TIMEOUT_EN
   logic [3:0] wd;
   logic       err_q;

   // Watchdog counts WAIT cycles; it expires on the cycle it would tick to 15.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wd <= '0;
      else if (state != S_WAIT) wd <= '0;
      else wd <= wd + 4'd1;
   end

   assign wd_expire = (state == S_WAIT) && (wd == 4'd14) && !bus.pe_done;

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else if (wd_expire) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign wd_expire = 1'b0;
   assign err       = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: if (tap == 4'd8) state_nxt = S_DRAIN;
         // Leave once the last stage holds the final tap: that accumulate
         // happens this cycle, so WAIT starts right when the PE can flag.
         S_DRAIN: if (!vld_pipe[0]) state_nxt = S_WAIT;
         S_WAIT: begin
            if (bus.pe_done) state_nxt = S_OUT;
            else if (wd_expire) state_nxt = S_IDLE;
         end
         S_OUT: begin
            if (bus.out_ready) state_nxt = (col_last && row_last) ? S_DONE : S_ISSUE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; addresses are forced to 0 outside ISSUE.
   always_comb begin
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);
      bus.in_re     = (state == S_ISSUE);
      bus.in_addr   = (state == S_ISSUE) ? pix_addr : '0;
      bus.f_addr    = (state == S_ISSUE) ? tap : 4'd0;
      bus.pe_mode   = {1'b0, vld_pipe[1]};
      bus.out_valid = (state == S_OUT);
      bus.out_data  = out_data_q;
      bus.out_addr  = OADDR_W'(row) * OADDR_W'(IMG_W - 2) + OADDR_W'(col);
   end

   // Two-stage delay line: read latency plus PE input register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_pipe <= '0;
      else vld_pipe <= {vld_pipe[0], bus.in_re};
   end

   // Window counters, tap counter and result capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row        <= '0;
         col        <= '0;
         tap        <= '0;
         out_data_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  row <= '0;
                  col <= '0;
                  tap <= '0;
               end
            end
            S_ISSUE: tap <= (tap == 4'd8) ? 4'd0 : tap + 4'd1;
            S_WAIT:  if (bus.pe_done) out_data_q <= bus.pe_result;
            S_OUT: begin
               if (bus.out_ready) begin
                  if (!col_last) col <= col + CW'(1);
                  else if (!row_last) begin
                     col <= '0;
                     row <= row + RW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// tb_conv3x3_seq_ctrl: random image/filter data, a behavioural PE and a
// window-level scoreboard built from the sliding-window definition.
module tb_conv3x3_seq_ctrl;
   localparam int W = 4, H = 4, AW = 6, OW = 6;
   localparam int NWIN = (W - 2) * (H - 2);

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic busy, done, err;

   conv3x3_seq_ctrl_if #(.ADDR_W(AW), .OADDR_W(OW)) bus ();

   conv3x3_seq_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OADDR_W(OW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
      end
   endtask

   logic [7:0] img [2**AW];
   logic [7:0] flt [9];
   int q_addr[$], q_f[$], q_res[$], q_oaddr[$];

   // Expected streams straight from the window definition.
   function automatic void build_exp();
      for (int r = 0; r <= H - 3; r++)
         for (int c = 0; c <= W - 3; c++) begin
            int s = 0;
            for (int t = 0; t < 9; t++) begin
               int a = (r + t / 3) * W + c + t % 3;
               q_addr.push_back(a);
               q_f.push_back(t);
               s += int'(img[a]) * int'(flt[t]);
            end
            q_res.push_back(s & 255);
            q_oaddr.push_back(r * (W - 2) + c);
         end
   endfunction

   function automatic void rand_data();
      for (int i = 0; i < 2**AW; i++) img[i] = 8'($urandom);
      for (int i = 0; i < 9; i++) flt[i] = 8'($urandom);
   endfunction

   // PE model / monitor state
   bit         p0_v, p1_v, fire, pe_mute, re_seen, pm_seen, stall_req, prev_stall;
   int         p0_a, p0_f, p1_a, p1_f, acc_n, cyc, win_acc, re_cyc, pm_cyc;
   int         n_done = 0, n_hs = 0, stall_left, rdy_pct = 100;
   logic [7:0] acc, res_hold, prev_data;
   int         prev_oaddr;

   // PE model, output sink and scoreboard; samples mid-cycle, drives for the next edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         p0_v = 0; p1_v = 0; fire = 0; acc = 0; acc_n = 0;
         win_acc = 0; re_seen = 0; pm_seen = 0; stall_left = 0; prev_stall = 0;
         bus.pe_done = 0; bus.pe_result = 0; bus.out_ready = 0;
      end else begin
         if (bus.in_re) begin
            if (!re_seen) begin re_seen = 1; re_cyc = cyc; end
            if (q_addr.size() == 0) chk("extra_in_re", 1, 0);
            else begin
               chk("in_addr", int'(bus.in_addr), q_addr.pop_front());
               chk("f_addr", int'(bus.f_addr), q_f.pop_front());
            end
         end
         bus.pe_done = fire;
         if (fire) bus.pe_result = res_hold;
         fire = 0;
         // Spurious flag while issuing must be ignored.
         if (!bus.pe_done && bus.in_re && $urandom_range(0, 5) == 0) begin
            bus.pe_done = 1;
            bus.pe_result = 8'($urandom);
         end
         if (bus.pe_mode == 2'b01) begin
            chk("pe_align", int'(p1_v), 1);
            if (!pm_seen) begin pm_seen = 1; pm_cyc = cyc; end
            win_acc++;
            acc = acc + img[p1_a] * flt[p1_f];
            acc_n++;
            if (acc_n == 9) begin
               acc_n = 0; res_hold = acc; acc = 0; fire = !pe_mute;
            end
         end else if (bus.pe_mode != 2'b00) chk("pe_mode_code", int'(bus.pe_mode), 0);
         p1_v = p0_v; p1_a = p0_a; p1_f = p0_f;
         p0_v = bus.in_re; p0_a = int'(bus.in_addr); p0_f = int'(bus.f_addr);
         if (prev_stall) begin
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_data", int'(bus.out_data), int'(prev_data));
            chk("stall_oaddr", int'(bus.out_addr), prev_oaddr);
         end
         if (bus.out_valid) chk("re_during_out", int'(bus.in_re), 0);
         if (bus.out_valid && stall_req) begin stall_left = 5; stall_req = 0; end
         if (stall_left > 0) begin bus.out_ready = 0; stall_left--; end
         else bus.out_ready = ($urandom_range(1, 100) <= rdy_pct);
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_oaddr = int'(bus.out_addr);
         if (bus.out_valid && bus.out_ready) begin
            n_hs++;
            if (q_res.size() == 0) chk("extra_result", 1, 0);
            else begin
               chk("out_data", int'(bus.out_data), q_res.pop_front());
               chk("out_addr", int'(bus.out_addr), q_oaddr.pop_front());
            end
            chk("acc_per_win", win_acc, 9);
            chk("pe_lag", pm_cyc - re_cyc, 2);
            win_acc = 0; re_seen = 0; pm_seen = 0;
         end
         if (done) n_done++;
      end
   end

   task automatic do_reset(input int n);
      rst = 0;
      repeat (n) @(negedge clk);
      q_addr.delete(); q_f.delete(); q_res.delete(); q_oaddr.delete();
      rst = 1;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_in_re"}, int'(bus.in_re), 0);
      chk({tag, "_in_addr"}, int'(bus.in_addr), 0);
      chk({tag, "_f_addr"}, int'(bus.f_addr), 0);
      chk({tag, "_pe_mode"}, int'(bus.pe_mode), 0);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_out_data"}, int'(bus.out_data), 0);
      chk({tag, "_out_addr"}, int'(bus.out_addr), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   task automatic run_pass(input string tag, input int pct, input bit stall, input bit poke);
      int d0 = n_done, hs0 = n_hs, k = 0;
      rdy_pct = pct; stall_req = stall;
      rand_data(); build_exp();
      pulse_start();
      if (poke) begin
         while (!(n_hs == hs0 + 1 && bus.in_re) && k < 500) begin @(negedge clk); k++; end
         chk({tag, "_poke_wait"}, int'(k < 500), 1);
         start = 1; @(negedge clk); start = 0;
      end
      k = 0;
      while (n_done == d0 && k < 2000) begin @(negedge clk); k++; end
      chk({tag, "_done_seen"}, int'(k < 2000), 1);
      repeat (3) @(negedge clk);
      chk({tag, "_done_pulses"}, n_done - d0, 1);
      chk({tag, "_results"}, n_hs - hs0, NWIN);
      chk({tag, "_busy_after"}, int'(busy), 0);
      chk({tag, "_left_reads"}, q_addr.size(), 0);
      chk({tag, "_left_results"}, q_res.size(), 0);
   endtask

   initial begin
      int k, d0;
      pe_mute = 0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1;
      repeat (2) @(negedge clk);

      run_pass("pass_fast", 100, 0, 0);
      run_pass("pass_stall", 60, 1, 1);
      run_pass("pass_slow", 30, 0, 0);

      // Abandon a pass mid-ISSUE.
      rdy_pct = 100; rand_data(); build_exp();
      pulse_start();
      repeat (3) @(negedge clk);
      rst = 0; #1;
      check_idle_outputs("rst_mid");
      d0 = n_done;
      do_reset(4);
      repeat (20) @(negedge clk);
      chk("rst_mid_no_done", n_done - d0, 0);
      chk("rst_mid_idle", int'(busy), 0);

      // PE never flags: WAIT behaviour.
      pe_mute = 1; rand_data(); build_exp();
      d0 = n_done;
      pulse_start();
      k = 0;
      while (!bus.in_re && k < 50) begin @(negedge clk); k++; end
      chk("mute_issue_seen", int'(bus.in_re), 1);
      repeat (25) @(negedge clk);
      chk("wait_err_before", int'(err), 0);
      chk("wait_busy_before", int'(busy), 1);
      @(negedge clk);
`ifdef CONV_TIMEOUT_EN
      chk("timeout_err", int'(err), 1);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_no_done", n_done - d0, 0);
      pe_mute = 0;
      q_addr.delete(); q_f.delete(); q_res.delete(); q_oaddr.delete();
      run_pass("after_err", 100, 0, 0);
      chk("err_sticky", int'(err), 1);
`else
      repeat (30) @(negedge clk);
      chk("wait_holds_busy", int'(busy), 1);
      chk("wait_err_zero", int'(err), 0);
      chk("wait_no_valid", int'(bus.out_valid), 0);
      chk("wait_no_done", n_done - d0, 0);
      pe_mute = 0;
      do_reset(3);
      repeat (2) @(negedge clk);
      check_idle_outputs("post_wait");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end
endmodule
